// File: rtl/aes_decrypt_scheduler_if.sv
// aes_decrypt_scheduler_if: two-requester block request / shared response bus
interface aes_decrypt_scheduler_if;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_data, req1_data;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready, rsp1_ready;
  logic [127:0] rsp_data;
  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );
  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );
endinterface

// File: rtl/aes_decrypt_scheduler.sv
// aes_decrypt_scheduler: round-robin sharing of one AES decipher core between two requesters
module aes_decrypt_scheduler #(
  parameter int NR  = 10,
  parameter int LAT = NR + 2
) (
  input  logic                        clk,
  input  logic                        reset,
  aes_decrypt_scheduler_if.slave      bus,
  output logic                        core_rst,
  output logic                        core_en,
  output logic [127:0]                core_in,
  input  logic [127:0]                core_out,
  output logic                        busy
);
  localparam int CW = $clog2(LAT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ptr_q, ptr_d, gnt_q, gnt_d;
  logic [127:0]   in_q, in_d, res_q, res_d;
  logic           pick, acc, rsp_hs;
  // choose the port to grant: on a tie the one not served last, otherwise whoever is valid
  always_comb begin
    pick = (bus.req0_valid && bus.req1_valid) ? ~ptr_q : bus.req1_valid;
    acc  = reset && (state_q == IDLE) && (pick ? bus.req1_valid : bus.req0_valid);
    rsp_hs = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;
  end
  // job sequencing: accept, restart core, run LAT rounds, hold result until taken
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    in_d    = in_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (acc) begin
        state_d = LOAD;
        gnt_d   = pick;
        in_d    = pick ? bus.req1_data : bus.req0_data;
      end
      LOAD: begin
        state_d = RUN;
        cnt_d   = CW'(LAT - 1);
      end
      RUN: if (cnt_q == '0) begin
        res_d   = core_out;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESP: if (rsp_hs) begin
        ptr_d   = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset abandons any in-flight block
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
      gnt_q   <= 1'b0;
      in_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      in_q    <= in_d;
      res_q   <= res_d;
    end
  end
  assign bus.req0_ready = acc && !pick;
  assign bus.req1_ready = acc && pick;
  assign bus.rsp0_valid = (state_q == RESP) && !gnt_q;
  assign bus.rsp1_valid = (state_q == RESP) && gnt_q;
  assign bus.rsp_data   = res_q;
  assign core_rst       = !reset || (state_q == LOAD);
  assign core_en        = (state_q == RUN);
  assign core_in        = in_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: doc/aes_decrypt_scheduler.md
AES_DECRYPT_SCHEDULER -- requirements
Module: aes_decrypt_scheduler

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES rounds.
REQ-002 SHALL have parameter LAT, default NR+2, cycles from core start until core_out holds the final result.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1 each  requester block offered.
REQ-006 SHALL have ports req0_ready, req1_ready  output  1 each  block accepted this cycle.
REQ-007 SHALL have ports req0_data, req1_data  input  128 each  ciphertext blocks.
REQ-008 SHALL have ports rsp0_valid, rsp1_valid  output  1 each  plaintext available.
REQ-009 SHALL have ports rsp0_ready, rsp1_ready  input  1 each  requester takes result.
REQ-010 SHALL have port rsp_data  output  128  plaintext; shared; meaningful only while a rsp*_valid is high.
REQ-011 SHALL have port core_rst  output  1  active-high restart pulse to the decipher core.
REQ-012 SHALL have port core_en  output  1  round enable to the core.
REQ-013 SHALL have port core_in  output  128  block presented to the core.
REQ-014 SHALL have port core_out  input  128  core result.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, RESP.
REQ-017 In IDLE, SHALL grant at most one requester, asserting its req*_ready combinationally while its req*_valid is high.
REQ-018 Arbitration SHALL be round-robin: if both valid, grant the port not served last; the last-served pointer resets to port 1, so port 0 wins the first tie.
REQ-019 On accept, SHALL register req*_data into core_in, latch the grant id, and go to LOAD.
REQ-020 LOAD SHALL last exactly 1 cycle with core_rst=1, core_en=0, then go to RUN.
REQ-021 RUN SHALL last exactly LAT cycles with core_en=1, core_rst=0, counted by a down-counter of width clog2(LAT+1) loaded with LAT-1.
REQ-022 On the final RUN cycle (counter 0), SHALL capture core_out into the result register and go to RESP.
REQ-023 In RESP, SHALL assert only the granted rsp*_valid with rsp_data = result register, both stable until handshake.
REQ-024 On rsp*_valid && rsp*_ready, SHALL update the last-served pointer, return to IDLE, and deassert rsp*_valid next cycle.
REQ-025 Latency SHALL be exactly LAT+2 cycles from the accepting edge to the first cycle rsp*_valid is high.
REQ-026 req*_ready SHALL be 0 in LOAD, RUN and RESP; new requests wait, and held valid/data are not lost.
REQ-027 The non-granted rsp*_ready SHALL be ignored; rsp*_ready in states other than RESP SHALL be ignored.
REQ-028 An accept SHALL occur on the cycle after RESP exits, never the same cycle.
REQ-029 core_in SHALL hold constant from LOAD through RESP.

Reset
REQ-030 On reset low, SHALL go to IDLE asynchronously, mid-job included; the in-flight block is discarded and no response is issued.
REQ-031 Reset values SHALL be: req*_ready=0 until first IDLE evaluation after release, rsp0_valid=rsp1_valid=0, rsp_data=0, core_in=0, core_rst=1, core_en=0, busy=0, counter 0, pointer = port 1.
REQ-032 core_rst SHALL stay high while reset is low, and stay low in IDLE after release.

Verification
REQ-033 Single job: req0 data 69c4e0d86a7b0430d8cdb78070b4c55a with FIPS-197 AES-128 keys -> rsp0_valid exactly LAT+2 cycles later, rsp_data 00112233445566778899aabbccddeeff.
REQ-034 Tie: req0 and req1 valid together from reset -> port 0 served first, then port 1; repeat tie -> port 0 again; rsp1_valid never high during port-0 job.
REQ-035 Backpressure: rsp0_ready held low 5 cycles -> rsp0_valid and rsp_data stable, req*_ready 0, busy 1 throughout.
REQ-036 Reset mid-RUN: assert reset at RUN cycle 3 -> outputs at reset values immediately; after release with no requests, rsp*_valid stays 0.
REQ-037 Back-to-back: req1 held valid during a port-0 job -> req1_ready pulses on the cycle after the rsp0 handshake; its core_rst pulse follows on the next cycle.
